// File: rtl/sample_ram_fifo.sv
// sample_ram_fifo: circular sample FIFO built on an external single-port
// 16-bit RAM with a 1-cycle synchronous read.
//
// The RAM port carries at most one operation per cycle. A prefetch READ is
// issued only when the output register is empty or being drained, so a
// returning word can never overwrite an unconsumed sample. Otherwise the
// port is free for input WRITEs. When the output register needs a refill,
// reads win; at most one write cycle is lost each time this happens.
//
// Optional build macro: SAMPLE_RAM_FIFO_OVERFLOW_EN
//   defined   - overflow is a sticky flag. It sets when in_valid is seen while
//               the FIFO is full, and it clears only on reset.
//   undefined - overflow is tied low and no detection logic is built.
//
// Reset is synchronous and active-low (reset_n).

module sample_ram_fifo #(
   parameter int unsigned ADDR_BITS = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   // input sample stream
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [15:0]          in_data,
   // output sample stream
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [15:0]          out_data,
   // occupancy
   output logic [ADDR_BITS:0]   level,
   // sample RAM port
   output logic [22:0]          mem_addr,
   output logic                 mem_we,
   output logic [15:0]          mem_din,
   input  logic [15:0]          mem_dout,
   // sticky error flag
   output logic                 overflow
);

   localparam int unsigned CNT_W  = ADDR_BITS + 1;
   localparam int unsigned MEM_AW = 23;
   localparam int unsigned DATA_W = 16;
   localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1) << ADDR_BITS;

   // RAM port operation chosen for the current cycle
   typedef enum logic [1:0] {
      OP_NONE  = 2'd0,
      OP_WRITE = 2'd1,
      OP_READ  = 2'd2
   } op_t;

   op_t                  op;
   logic [ADDR_BITS-1:0] wr_ptr;
   logic [ADDR_BITS-1:0] rd_ptr;
   logic [CNT_W-1:0]     count;
   logic                 rd_pend;
   logic                 full;
   logic                 empty;
   logic                 rd_req;

   logic [CNT_W-1:0]     count_nxt;
   logic                 rd_pend_nxt;
   logic                 out_valid_nxt;
   logic [CNT_W-1:0]     level_nxt;

   // Port arbitration: a refill read beats a write; nothing happens while in reset
   always_comb begin
      op       = OP_NONE;
      full     = (count == DEPTH);
      empty    = (count == '0);
      rd_req   = !empty && !rd_pend && (!out_valid || out_ready);
      in_ready = reset_n && !full && !rd_req;
      if (!reset_n) begin
         op = OP_NONE;
      end else if (rd_req) begin
         op = OP_READ;
      end else if (in_valid && !full) begin
         op = OP_WRITE;
      end
   end

   // RAM address/data/enable follow the operation selected this cycle
   always_comb begin
      mem_addr = '0;
      mem_we   = 1'b0;
      mem_din  = '0;
      case (op)
         OP_WRITE: begin
            mem_addr = MEM_AW'(wr_ptr);
            mem_we   = 1'b1;
            mem_din  = in_data;
         end
         OP_READ: begin
            mem_addr = MEM_AW'(rd_ptr);
         end
         default: begin
            mem_addr = '0;
         end
      endcase
   end

   // Next-state values, also used to produce a level that matches the registered state
   always_comb begin
      count_nxt     = count;
      rd_pend_nxt   = (op == OP_READ);
      out_valid_nxt = out_valid;
      case (op)
         OP_WRITE: count_nxt = count + CNT_W'(1);
         OP_READ:  count_nxt = count - CNT_W'(1);
         default:  count_nxt = count;
      endcase
      if (rd_pend) begin
         out_valid_nxt = 1'b1;
      end else if (out_valid && out_ready) begin
         out_valid_nxt = 1'b0;
      end
      level_nxt = count_nxt + CNT_W'(rd_pend_nxt) + CNT_W'(out_valid_nxt);
   end

   // Pointer, count and occupancy registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         rd_pend <= 1'b0;
         level   <= '0;
      end else begin
         if (op == OP_WRITE) begin
            wr_ptr <= wr_ptr + ADDR_BITS'(1);
         end
         if (op == OP_READ) begin
            rd_ptr <= rd_ptr + ADDR_BITS'(1);
         end
         count   <= count_nxt;
         rd_pend <= rd_pend_nxt;
         level   <= level_nxt;
      end
   end

   // Output register: capture returning RAM data, drop it once consumed
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         out_valid <= out_valid_nxt;
         if (rd_pend) begin
            out_data <= DATA_W'(mem_dout);
         end
      end
   end

`ifdef SAMPLE_RAM_FIFO_OVERFLOW_EN
   logic overflow_q;

   // Sticky flag for producers that push while the FIFO is full
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         overflow_q <= 1'b0;
      end else if (in_valid && full) begin
         overflow_q <= 1'b1;
      end
   end

   assign overflow = overflow_q;
`else
   assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_sample_ram_fifo.sv
// Directed bench for sample_ram_fifo with a 16-word FIFO (ADDR_BITS=4) and a
// behavioural 1-cycle-latency sample RAM. Inputs change at the falling edge,
// and outputs are sampled 1 time unit after that.

module tb_sample_ram_fifo;

   localparam int unsigned AB    = 4;
   localparam int unsigned DEPTH = 1 << AB;
`ifdef SAMPLE_RAM_FIFO_OVERFLOW_EN
   localparam logic EXP_OVF = 1'b1;
`else
   localparam logic EXP_OVF = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset_n;
   logic          in_valid;
   logic          in_ready;
   logic [15:0]   in_data;
   logic          out_valid;
   logic          out_ready;
   logic [15:0]   out_data;
   logic [AB:0]   level;
   logic [22:0]   mem_addr;
   logic          mem_we;
   logic [15:0]   mem_din;
   logic [15:0]   mem_dout;
   logic          overflow;

   logic [15:0]   ram [0:DEPTH-1];

   int n_checks = 0;
   int n_fail   = 0;

   sample_ram_fifo #(.ADDR_BITS(AB)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .level     (level),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_din   (mem_din),
      .mem_dout  (mem_dout),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   // behavioural single-port RAM, synchronous read
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr[AB-1:0]] <= mem_din;
      mem_dout <= ram[mem_addr[AB-1:0]];
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      tick(); tick();
      reset_n = 1'b1;
      repeat (10) tick();
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      n_checks++; if (level !== '0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
      n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
   endtask

   task automatic test_single();
      in_valid = 1'b1; in_data = 16'h1234; out_ready = 1'b1;
      #1;   // cycle N
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_in_ready: got %b expected 1", in_ready); end
      n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL single_we: got %b expected 1", mem_we); end
      n_checks++; if (mem_addr !== 23'd0) begin n_fail++; $display("FAIL single_addr: got %0h expected 0", mem_addr); end
      n_checks++; if (mem_din !== 16'h1234) begin n_fail++; $display("FAIL single_din: got %h expected 1234", mem_din); end
      tick(); in_valid = 1'b0; #1;   // N+1: read issued
      n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL single_read_we: got %b expected 0", mem_we); end
      n_checks++; if (level !== 5'd1) begin n_fail++; $display("FAIL single_level_n1: got %0d expected 1", level); end
      tick(); #1;   // N+2: read in flight
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_ov_n2: got %b expected 0", out_valid); end
      n_checks++; if (level !== 5'd1) begin n_fail++; $display("FAIL single_level_n2: got %0d expected 1", level); end
      tick(); #1;   // N+3: sample presented
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_ov_n3: got %b expected 1", out_valid); end
      n_checks++; if (out_data !== 16'h1234) begin n_fail++; $display("FAIL single_data_n3: got %h expected 1234", out_data); end
      tick(); #1;   // N+4: consumed
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_ov_n4: got %b expected 0", out_valid); end
      n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL single_level_n4: got %0d expected 0", level); end
   endtask

   task automatic test_stream();
      int sent = 0;
      int recv = 0;
      int cyc  = 0;
      out_ready = 1'b1;
      while (recv < 256 && cyc < 3000) begin
         in_valid = (sent < 256);
         in_data  = 16'(sent);
         #1;
         n_checks++;
         if (mem_addr[22:AB] !== '0) begin n_fail++; $display("FAIL stream_addr_hi: got %h expected 0", mem_addr); end
         if (in_valid && in_ready) sent++;
         if (out_valid && out_ready) begin
            n_checks++;
            if (out_data !== 16'(recv)) begin n_fail++; $display("FAIL stream_data: got %h expected %h", out_data, 16'(recv)); end
            recv++;
         end
         tick();
         cyc++;
      end
      in_valid = 1'b0;
      n_checks++; if (recv != 256) begin n_fail++; $display("FAIL stream_count: got %0d expected 256", recv); end
      tick(); #1;
      n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL stream_level_end: got %0d expected 0", level); end
   endtask

   task automatic test_full_wrap();
      int acc  = 0;
      int recv = 0;
      int sent = 0;
      int cyc  = 0;
      out_ready = 1'b0;
      for (int c = 0; c < 40; c++) begin
         in_valid = (acc < 20);
         in_data  = 16'h0A00 + 16'(acc);
         #1;
         if (in_valid && in_ready) acc++;
         tick();
      end
      #1;
      n_checks++; if (acc != 17) begin n_fail++; $display("FAIL full_accepted: got %0d expected 17", acc); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
      n_checks++; if (level !== 5'd17) begin n_fail++; $display("FAIL full_level: got %0d expected 17", level); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL full_out_valid: got %b expected 1", out_valid); end
      // drain everything in order
      in_valid = 1'b0; out_ready = 1'b1;
      while (recv < 17 && cyc < 100) begin
         #1;
         if (out_valid) begin
            n_checks++;
            if (out_data !== 16'h0A00 + 16'(recv)) begin n_fail++; $display("FAIL drain_data: got %h expected %h", out_data, 16'h0A00 + 16'(recv)); end
            recv++;
         end
         tick();
         cyc++;
      end
      #1;
      n_checks++; if (recv != 17) begin n_fail++; $display("FAIL drain_count: got %0d expected 17", recv); end
      n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL drain_level: got %0d expected 0", level); end
      // 40 more words push both pointers around the 15 -> 0 wrap
      recv = 0; cyc = 0;
      while (recv < 40 && cyc < 500) begin
         in_valid = (sent < 40);
         in_data  = 16'hB000 + 16'(sent);
         #1;
         if (in_valid && in_ready) sent++;
         if (out_valid && out_ready) begin
            n_checks++;
            if (out_data !== 16'hB000 + 16'(recv)) begin n_fail++; $display("FAIL wrap_data: got %h expected %h", out_data, 16'hB000 + 16'(recv)); end
            recv++;
         end
         tick();
         cyc++;
      end
      in_valid = 1'b0;
      n_checks++; if (recv != 40) begin n_fail++; $display("FAIL wrap_count: got %0d expected 40", recv); end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0; in_valid = 1'b1; in_data = 16'hDEAD;
      #1;   // cycle N: write
      n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL rmid_write: got %b expected 1", mem_we); end
      tick(); in_valid = 1'b0; #1;   // N+1: read issued
      n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rmid_read_we: got %b expected 0", mem_we); end
      tick();   // N+2: read returning, reset pulsed here
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid: got %b expected 0", out_valid); end
         n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL rmid_level: got %0d expected 0", level); end
         tick();
      end
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready: got %b expected 1", in_ready); end
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rmid_overflow: got %b expected 0", overflow); end
   endtask

   task automatic test_overflow();
      int acc  = 0;
      int recv = 0;
      int cyc  = 0;
      out_ready = 1'b0; in_valid = 1'b1;
      while (acc < 17 && cyc < 60) begin
         in_data = 16'hC000 + 16'(acc);
         #1;
         if (in_ready) acc++;
         tick();
         cyc++;
      end
      #1;   // just became full; in_valid still high
      n_checks++; if (acc != 17) begin n_fail++; $display("FAIL ovf_accepted: got %0d expected 17", acc); end
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_before: got %b expected 0", overflow); end
      tick(); #1;
      n_checks++; if (overflow !== EXP_OVF) begin n_fail++; $display("FAIL ovf_set: got %b expected %b", overflow, EXP_OVF); end
      in_valid = 1'b0; out_ready = 1'b1; cyc = 0;
      while (recv < 17 && cyc < 100) begin
         #1;
         if (out_valid) begin
            n_checks++;
            if (out_data !== 16'hC000 + 16'(recv)) begin n_fail++; $display("FAIL ovf_drain_data: got %h expected %h", out_data, 16'hC000 + 16'(recv)); end
            recv++;
         end
         tick();
         cyc++;
      end
      #1;
      n_checks++; if (recv != 17) begin n_fail++; $display("FAIL ovf_drain_count: got %0d expected 17", recv); end
      n_checks++; if (overflow !== EXP_OVF) begin n_fail++; $display("FAIL ovf_sticky: got %b expected %b", overflow, EXP_OVF); end
   endtask

   initial begin
      reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      @(negedge clk);
      test_reset();
      test_single();
      test_stream();
      test_full_wrap();
      test_reset_mid();
      test_overflow();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sample_ram_fifo.md
Name: sample_ram_fifo

Overview:
- Circular FIFO controller over the external single-port 16-bit sample RAM (23-bit address, write-enable, synchronous read with 1-cycle latency).
- Sits directly upstream of that RAM and owns its addr/we/din.
- Accepts 16-bit audio samples on a valid/ready input stream and returns them in order on a valid/ready output stream.
- Arbitrates the single RAM port between writes and prefetch reads.

Parameters:
- ADDR_BITS, 16, log2 of FIFO depth in words. Depth = 2^ADDR_BITS. Must be ≤ 23. Default matches the simulation RAM capacity.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  controller accepts in_data this cycle.
- in_data  in  16  input sample.
- out_valid  out  1  out_data holds a sample.
- out_ready  in  1  consumer takes out_data this cycle.
- out_data  out  16  output sample.
- level  out  ADDR_BITS+1  total samples held: RAM count + read in flight + output register.
- mem_addr  out  23  RAM address. Bits above ADDR_BITS are always 0.
- mem_we  out  1  RAM write enable.
- mem_din  out  16  RAM write data.
- mem_dout  in  16  RAM read data, valid the cycle after a read address is presented.
- overflow  out  1  sticky error flag; see Optional Feature.

Behaviour:
- Reset (reset_n=0 at posedge): wr_ptr=0, rd_ptr=0, count=0, rd_pend=0, out_valid=0, out_data=0, level=0, overflow=0, mem_we=0. mem_addr/mem_din are don't-care but driven 0.
- Reset mid-operation discards all stored data and any in-flight read. mem_dout returning the cycle after reset is ignored.
- count = words in RAM not yet read. full = (count == 2^ADDR_BITS). empty = (count == 0).
- Exactly one RAM operation per cycle: READ, WRITE or NONE. The decision is combinational in the current cycle and registered at the posedge:
  - rd_req = !empty && !rd_pend && (!out_valid || out_ready).
  - READ if rd_req. Else WRITE if in_valid && !full. Else NONE.
- in_ready = !full && !rd_req. Combinational; an input transfer occurs when in_valid && in_ready.
- WRITE: mem_addr = wr_ptr, mem_we = 1, mem_din = in_data in the same cycle as the handshake. On the posedge, wr_ptr increments.
- READ: mem_addr = rd_ptr, mem_we = 0. On the posedge, rd_ptr increments, count decrements, rd_pend is set.
- Pointers are ADDR_BITS wide and wrap naturally from 2^ADDR_BITS-1 to 0.
- Cycle after a READ (rd_pend=1): out_data <= mem_dout, out_valid <= 1, rd_pend <= 0.
- rd_req requires the output register to be free or draining, so a capture never overwrites an unconsumed word.
- Output handshake: transfer when out_valid && out_ready. If no capture occurs the same cycle, out_valid <= 0.
- Latency, empty FIFO: input accepted cycle N → RAM write at N → read issued N+1 → out_valid=1 in N+3.
- Steady state: throughput is up to one write and one read per two cycles combined. Reads take priority only when the output register needs refilling, so writes cannot be starved for more than 1 consecutive cycle.
- Simultaneous count update (write and read in one cycle) is impossible by construction. count changes by +1 on WRITE and -1 on READ.
- level = count + rd_pend + out_valid, registered, updated every cycle.
- Full: in_ready=0. Data presented stays with the producer; no loss inside the controller.
- Empty with out_valid=0: out_valid stays 0 and RAM idles (mem_we=0).

Optional Feature:
- Macro: SAMPLE_RAM_FIFO_OVERFLOW_EN.
- Defined: overflow is set on any cycle with in_valid=1 while full=1, and stays set until reset. Used to flag producers that do not honour ready (e.g. fixed-rate ADC paths).
- Undefined: overflow is tied to 0 and no detection logic is built.

Test Plan:
- Reset then idle 10 cycles → out_valid=0, level=0, mem_we=0, in_ready=1.
- Write single sample 0x1234 with out_ready=1 → mem_we at cycle N, addr 0; out_valid=1, out_data=0x1234 at N+3; level returns to 0 after the consume.
- Stream 0x0000..0x00FF with in_valid held and out_ready held → output is the identical ordered sequence with no duplicates or gaps; every cycle has ≤1 RAM op.
- ADDR_BITS=4, out_ready=0, push 20 words → 17 accepted (16 in RAM + 1 in output register); in_ready=0 after that; level=17. Drain all 17 in order. Push 40 more → pointers wrap past 15→0 and data is intact.
- Pulse reset_n=0 one cycle immediately after a READ issue → out_valid stays 0, level=0, stale mem_dout is not captured.
- With SAMPLE_RAM_FIFO_OVERFLOW_EN and ADDR_BITS=4: fill (17 words) then hold in_valid=1 → overflow=1 next cycle and stays 1 after draining. Without the macro → overflow=0 throughout.
